// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and parity helper for the UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    // Unused upper bits must be zero so they do not disturb the XOR.
    function automatic logic parity_level(parity_t mode, logic [8:0] bits);
        return (mode == PARITY_ODD) ? ~(^bits) : ^bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - enqueue handshake bundle for the UART transmitter
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [WIDTH-1:0]               wdata_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !reset_i) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter: FIFO, frame FSM, bit timer
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int      CLKS_PER_BIT = 217,
    parameter int      DATA_BITS    = 8,
    parameter parity_t PARITY       = PARITY_NONE,
    parameter int      STOP_BITS    = 1,
    parameter int      FIFO_DEPTH   = 4
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [DATA_BITS-1:0]                tx_data_i,
    input  logic                                tx_valid_i,
    output logic                                tx_ready_o,
    output logic                                tx_serial_o,
    output logic                                busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 serial_q, serial_d;
    logic                 bit_end;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    assign tx_ready_o  = ~fifo_full;
    assign fifo_push   = tx_valid_i & tx_ready_o;
    assign busy_o      = (state_q != IDLE);
    assign tx_serial_o = serial_q;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (tx_data_i),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_o)
    );

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;

        if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = START;
                    cnt_d    = '0;
                    idx_d    = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY == PARITY_NONE) ? STOP : PAR;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q != STOP_LAST) begin
                        idx_d = idx_q + 1'b1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next frame with no idle bit.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = START;
                        idx_d    = '0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line register follows the FSM by one cycle, so each level lasts
    // exactly as long as the state that produced it.
    always_comb begin
        serial_d = 1'b1;
        case (state_q)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_q[idx_q];
            PAR:     serial_d = parity_level(PARITY, 9'(shift_q));
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed and scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst;
    logic [3:0] drv_valid;
    logic [8:0] drv_data [4];
    logic [3:0] ser, busy, rdy;
    logic [2:0] cnt [4];
    logic [8:0] sb_q [$];

    int checks = 0;
    int errors = 0;

    uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if1 ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if2 ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if3 ();

    assign if0.tx_data = drv_data[0][7:0];
    assign if1.tx_data = drv_data[1][7:0];
    assign if2.tx_data = drv_data[2][7:0];
    assign if3.tx_data = drv_data[3][6:0];
    assign if0.tx_valid = drv_valid[0];
    assign if1.tx_valid = drv_valid[1];
    assign if2.tx_valid = drv_valid[2];
    assign if3.tx_valid = drv_valid[3];
    assign rdy = {if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk_i(clk), .reset_i(rst[0]), .tx_data_i(if0.tx_data), .tx_valid_i(if0.tx_valid),
        .tx_ready_o(if0.tx_ready), .tx_serial_o(ser[0]), .busy_o(busy[0]), .fifo_count_o(cnt[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk_i(clk), .reset_i(rst[1]), .tx_data_i(if1.tx_data), .tx_valid_i(if1.tx_valid),
        .tx_ready_o(if1.tx_ready), .tx_serial_o(ser[1]), .busy_o(busy[1]), .fifo_count_o(cnt[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
        .clk_i(clk), .reset_i(rst[2]), .tx_data_i(if2.tx_data), .tx_valid_i(if2.tx_valid),
        .tx_ready_o(if2.tx_ready), .tx_serial_o(ser[2]), .busy_o(busy[2]), .fifo_count_o(cnt[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PARITY_NONE), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut3 (
        .clk_i(clk), .reset_i(rst[3]), .tx_data_i(if3.tx_data), .tx_valid_i(if3.tx_valid),
        .tx_ready_o(if3.tx_ready), .tx_serial_o(ser[3]), .busy_o(busy[3]), .fifo_count_o(cnt[3]));

    // Bench receiver: waits for a start bit, then samples every cycle of every bit.
    task automatic rx_frame(input int k, input int dbits, input int pm, input int sb,
                            output logic [8:0] data, output logic par, output logic frame_ok,
                            output int busy_cnt, output logic timed_out);
        int   nb;
        int   g;
        logic lev;
        nb = 1 + dbits + ((pm != 0) ? 1 : 0) + sb;
        data = '0; par = 1'b0; frame_ok = 1'b1; busy_cnt = 0; timed_out = 1'b0; g = 0;
        while (ser[k] !== 1'b0 && g < 3000) begin @(negedge clk); g++; end
        if (ser[k] !== 1'b0) begin timed_out = 1'b1; frame_ok = 1'b0; return; end
        for (int b = 0; b < nb; b++) begin
            lev = ser[k];
            for (int c = 0; c < CPB; c++) begin
                if (ser[k] !== lev) frame_ok = 1'b0;
                if (busy[k] === 1'b1) busy_cnt++;
                @(negedge clk);
            end
            if (b == 0) begin
                if (lev !== 1'b0) frame_ok = 1'b0;
            end else if (b <= dbits) begin
                data[b-1] = lev;
            end else if (pm != 0 && b == dbits + 1) begin
                par = lev;
            end else if (lev !== 1'b1) begin
                frame_ok = 1'b0;
            end
        end
    endtask

    task automatic push_one(input int k, input logic [8:0] d);
        @(negedge clk);
        drv_valid[k] = 1'b1;
        drv_data[k]  = d;
        @(negedge clk);
        drv_valid[k] = 1'b0;
        drv_data[k]  = 9'h1FF;
    endtask

    task automatic test_reset();
        rst = 4'hF;
        drv_valid = 4'b0001;
        drv_data[0] = 9'h033;
        repeat (3) @(negedge clk);
        checks++; if (ser !== 4'hF) begin errors++; $display("FAIL reset_serial: got %b want 1111", ser); end
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b want 0000", busy); end
        checks++; if (rdy !== 4'hF) begin errors++; $display("FAIL reset_ready: got %b want 1111", rdy); end
        checks++; if (cnt[0] !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt[0]); end
        rst = 4'h0;
        drv_valid = 4'b0000;
        repeat (2) @(negedge clk);
        checks++; if (cnt[0] !== 3'd0 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL reset_push_dropped: got count=%0d busy=%b want 0 0", cnt[0], busy[0]); end
    endtask

    task automatic test_8n1();
        logic [8:0] d; logic p, ok, to; int bc;
        push_one(0, 9'h0A5);
        @(negedge clk);
        checks++; if (ser[0] !== 1'b1 || busy[0] !== 1'b1) begin
            errors++; $display("FAIL 8n1_pop_cycle: got ser=%b busy=%b want 1 1", ser[0], busy[0]); end
        @(negedge clk);
        checks++; if (ser[0] !== 1'b0) begin errors++; $display("FAIL 8n1_start_latency: got %b want 0", ser[0]); end
        rx_frame(0, 8, 0, 1, d, p, ok, bc, to);
        checks++; if (to || !ok || d !== 9'h0A5) begin
            errors++; $display("FAIL 8n1_frame: got data=%h ok=%b to=%b want 0a5 1 0", d, ok, to); end
        // busy also covered the pop cycle before the line fell: 39 + 1 = 40
        checks++; if (bc !== 39 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL 8n1_busy: got cnt=%0d busy_now=%b want 39 0", bc, busy[0]); end
    endtask

    task automatic test_parity();
        logic [8:0] d; logic p, ok, to; int bc;
        push_one(1, 9'h007);
        rx_frame(1, 8, 1, 1, d, p, ok, bc, to);
        checks++; if (to || !ok || d !== 9'h007 || p !== 1'b1) begin
            errors++; $display("FAIL 8e1_parity: got data=%h par=%b ok=%b want 007 1 1", d, p, ok); end
        push_one(2, 9'h007);
        rx_frame(2, 8, 2, 1, d, p, ok, bc, to);
        checks++; if (to || !ok || d !== 9'h007 || p !== 1'b0) begin
            errors++; $display("FAIL 8o1_parity: got data=%h par=%b ok=%b want 007 0 1", d, p, ok); end
        push_one(3, 9'h07F);
        rx_frame(3, 7, 0, 2, d, p, ok, bc, to);
        checks++; if (to || !ok || d !== 9'h07F || bc !== 39) begin
            errors++; $display("FAIL 7n2_frame: got data=%h ok=%b busy=%0d want 07f 1 39", d, ok, bc); end
    endtask

    task automatic test_fifo_full();
        logic [8:0] d; logic p, ok, to; int bc; logic low_seen;
        logic [8:0] exp [5];
        exp = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h014};
        push_one(0, 9'h010);
        fork
            begin
                @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    drv_valid[0] = 1'b1;
                    drv_data[0]  = 9'(9'h011 + i);
                    checks++; if (rdy[0] !== (i < 4)) begin
                        errors++; $display("FAIL full_ready_%0d: got %b want %b", i, rdy[0], (i < 4)); end
                    @(negedge clk);
                end
                drv_valid[0] = 1'b0;
                drv_data[0]  = 9'h0FF;
                checks++; if (cnt[0] !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", cnt[0]); end
            end
            begin
                for (int f = 0; f < 5; f++) begin
                    if (f > 0) begin
                        checks++; if (ser[0] !== 1'b0) begin errors++; $display("FAIL b2b_gap_%0d: got %b want 0", f, ser[0]); end
                    end
                    rx_frame(0, 8, 0, 1, d, p, ok, bc, to);
                    checks++; if (to || !ok || d !== exp[f]) begin
                        errors++; $display("FAIL b2b_frame_%0d: got data=%h ok=%b want %h 1", f, d, ok, exp[f]); end
                end
            end
        join
        low_seen = 1'b0;
        repeat (150) begin @(negedge clk); if (ser[0] !== 1'b1) low_seen = 1'b1; end
        checks++; if (low_seen || cnt[0] !== 3'd0) begin
            errors++; $display("FAIL full_refused: got extra_frame=%b count=%0d want 0 0", low_seen, cnt[0]); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] d; logic p, ok, to; int bc;
        logic [8:0] exp [3];
        exp = '{9'h03C, 9'h0C3, 9'h05A};
        fork
            begin
                @(negedge clk);
                drv_valid[0] = 1'b1; drv_data[0] = 9'h03C;
                @(negedge clk);
                drv_data[0] = 9'h0C3;
                @(negedge clk);
                drv_valid[0] = 1'b0; drv_data[0] = 9'h1FF;
                checks++; if (cnt[0] !== 3'd1) begin errors++; $display("FAIL idle_push_pop_count: got %0d want 1", cnt[0]); end
                repeat (39) @(negedge clk);
                drv_valid[0] = 1'b1; drv_data[0] = 9'h05A;
                @(negedge clk);
                drv_valid[0] = 1'b0; drv_data[0] = 9'h1FF;
                checks++; if (cnt[0] !== 3'd1 || busy[0] !== 1'b1 || ser[0] !== 1'b1) begin
                    errors++; $display("FAIL stop_push_pop: got count=%0d busy=%b ser=%b want 1 1 1", cnt[0], busy[0], ser[0]); end
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    if (f > 0) begin
                        checks++; if (ser[0] !== 1'b0) begin errors++; $display("FAIL pp_gap_%0d: got %b want 0", f, ser[0]); end
                    end
                    rx_frame(0, 8, 0, 1, d, p, ok, bc, to);
                    checks++; if (to || !ok || d !== exp[f]) begin
                        errors++; $display("FAIL pp_frame_%0d: got data=%h ok=%b want %h 1", f, d, ok, exp[f]); end
                end
            end
        join
    endtask

    task automatic test_reset_midframe();
        logic bad;
        @(negedge clk);
        drv_valid[0] = 1'b1; drv_data[0] = 9'h096;
        @(negedge clk); drv_data[0] = 9'h069;
        @(negedge clk); drv_data[0] = 9'h0F0;
        @(negedge clk); drv_valid[0] = 1'b0; drv_data[0] = 9'h1FF;
        checks++; if (cnt[0] !== 3'd2) begin errors++; $display("FAIL midframe_queued: got %0d want 2", cnt[0]); end
        repeat (17) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        checks++; if (ser[0] !== 1'b1 || busy[0] !== 1'b0 || cnt[0] !== 3'd0 || rdy[0] !== 1'b1) begin
            errors++; $display("FAIL midframe_reset: got ser=%b busy=%b count=%0d ready=%b want 1 0 0 1",
                              ser[0], busy[0], cnt[0], rdy[0]); end
        rst[0] = 1'b0;
        bad = 1'b0;
        repeat (300) begin @(negedge clk); if (ser[0] !== 1'b1 || busy[0] !== 1'b0) bad = 1'b1; end
        checks++; if (bad) begin errors++; $display("FAIL midframe_discard: got activity=1 want 0"); end
    endtask

    task automatic test_scoreboard(input int k, input int pm, input int n);
        logic [8:0] d, e; logic p, ok, to, ep; int bc;
        fork
            begin
                int i, guard;
                i = 0; guard = 0;
                while (i < n && guard < 20000) begin
                    @(negedge clk); guard++;
                    if (rdy[k]) begin
                        drv_data[k] = 9'($urandom_range(0, 255));
                        drv_valid[k] = 1'b1;
                        sb_q.push_back(drv_data[k]);
                        i++;
                    end else begin
                        drv_valid[k] = 1'b0;
                    end
                end
                @(negedge clk);
                drv_valid[k] = 1'b0;
            end
            begin
                for (int f = 0; f < n; f++) begin
                    rx_frame(k, 8, pm, 1, d, p, ok, bc, to);
                    e = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
                    ep = (pm == 2) ? ~(^e[7:0]) : ^e[7:0];
                    checks++; if (to || !ok || d !== e || (pm != 0 && p !== ep)) begin
                        errors++; $display("FAIL sb_mode%0d_frame%0d: got data=%h par=%b ok=%b want %h %b 1",
                                          pm, f, d, p, ok, e, ep); end
                end
            end
        join
    endtask

    initial begin
        rst = 4'hF;
        drv_valid = 4'h0;
        for (int k = 0; k < 4; k++) drv_data[k] = '0;
        test_reset();
        test_8n1();
        test_parity();
        test_fifo_full();
        test_back_to_back();
        test_reset_midframe();
        test_scoreboard(0, 0, 67);
        test_scoreboard(1, 1, 67);
        test_scoreboard(2, 2, 66);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
